// File: rtl/fetch_sequencer_if.sv
// Fetch front-end bundle: the instruction-memory req/ack port, the valid/ready
// decoder port and the decoder's jump/branch resolution coming back.
interface fetch_sequencer_if #(
   parameter int DATA_W = 32
);
   logic              imem_req;
   logic [31:0]       imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_rdata;
   logic [DATA_W-1:0] instr_out;
   logic [31:0]       instr_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic              jump;
   logic [25:0]       jump_target;
   logic              branch_taken;
   logic [15:0]       branch_offset;
   logic [31:0]       fetch_count;

   modport master (
      output imem_req, imem_addr, instr_out, instr_pc, instr_valid, fetch_count,
      input  imem_ack, imem_rdata, instr_ready, jump, jump_target, branch_taken, branch_offset
   );

   modport slave (
      input  imem_req, imem_addr, instr_out, instr_pc, instr_valid, fetch_count,
      output imem_ack, imem_rdata, instr_ready, jump, jump_target, branch_taken, branch_offset
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, fetches one word at a time and hands
// it to the decoder, redirecting on jump/branch when the decoder accepts it.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   fetch_sequencer_if.master bus
);
   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   state_t            state_reg;
   logic [31:0]       pc_reg;
   logic [31:0]       instr_pc_reg;
   logic [31:0]       fetch_count_reg;
   logic [DATA_W-1:0] instr_out_reg;
   logic              imem_req_reg;
   logic              instr_valid_reg;

   logic [31:0] instr_pc_plus4;
   logic [31:0] jump_pc;
   logic [31:0] branch_off_ext;
   logic [31:0] branch_pc;

   // Offsets are word-scaled, so the low two bits of every target stay zero.
   assign instr_pc_plus4 = instr_pc_reg + 32'd4;
   assign jump_pc        = {instr_pc_plus4[31:28], bus.jump_target, 2'b00};
   assign branch_off_ext = {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
   assign branch_pc      = instr_pc_plus4 + branch_off_ext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         pc_reg          <= RESET_PC_ALIGNED;
         instr_pc_reg    <= RESET_PC_ALIGNED;
         instr_out_reg   <= '0;
         fetch_count_reg <= '0;
         imem_req_reg    <= 1'b0;
         instr_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               state_reg    <= REQ;
               imem_req_reg <= 1'b1;
            end
            REQ: begin
               if (bus.imem_ack) begin
                  instr_out_reg   <= bus.imem_rdata;
                  instr_pc_reg    <= pc_reg;
                  instr_valid_reg <= 1'b1;
                  pc_reg          <= pc_reg + 32'd4;
                  imem_req_reg    <= 1'b0;
                  state_reg       <= HOLD;
               end
            end
            HOLD: begin
               // Redirect inputs only matter on the accept edge; jump beats branch.
               if (bus.instr_ready) begin
                  instr_valid_reg <= 1'b0;
                  fetch_count_reg <= fetch_count_reg + 32'd1;
                  imem_req_reg    <= 1'b1;
                  state_reg       <= REQ;
                  if (bus.jump)
                     pc_reg <= jump_pc;
                  else if (bus.branch_taken)
                     pc_reg <= branch_pc;
               end
            end
            default: begin
               state_reg    <= IDLE;
               imem_req_reg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req    = imem_req_reg;
   assign bus.imem_addr   = pc_reg;
   assign bus.instr_out   = instr_out_reg;
   assign bus.instr_pc    = instr_pc_reg;
   assign bus.instr_valid = instr_valid_reg;
   assign bus.fetch_count = fetch_count_reg;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, sequential fetch, backpressure,
// jump/branch redirects with wrap-around, and reset during a pending request.
module tb_fetch_sequencer;
   localparam logic [31:0] RPC = 32'h0040_0000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_mis = 0;

   fetch_sequencer_if #(.DATA_W(32)) bus ();

   fetch_sequencer #(.RESET_PC(RPC), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_word(input logic [31:0] addr, input logic [31:0] data, input int wait_cycles);
      check("req_before_ack", {31'd0, bus.imem_req}, 32'd1);
      check("addr_before_ack", bus.imem_addr, addr);
      for (int i = 0; i < wait_cycles; i++) begin
         tick();
         check("req_held", {31'd0, bus.imem_req}, 32'd1);
         check("addr_stable", bus.imem_addr, addr);
      end
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = data;
      tick();
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'h5555_AAAA;
      check("valid_after_ack", {31'd0, bus.instr_valid}, 32'd1);
      check("instr_out", bus.instr_out, data);
      check("instr_pc", bus.instr_pc, addr);
      check("req_low_in_hold", {31'd0, bus.imem_req}, 32'd0);
      $display("fetch   addr=%h data=%h wait=%0d", addr, data, wait_cycles);
   endtask

   task automatic accept(input logic j, input logic [25:0] tgt, input logic br,
                         input logic [15:0] off, input logic [31:0] next_addr,
                         input logic [31:0] count);
      bus.instr_ready   = 1'b1;
      bus.jump          = j;
      bus.jump_target   = tgt;
      bus.branch_taken  = br;
      bus.branch_offset = off;
      tick();
      bus.instr_ready   = 1'b0;
      bus.jump          = 1'b0;
      bus.jump_target   = '0;
      bus.branch_taken  = 1'b0;
      bus.branch_offset = '0;
      check("valid_after_accept", {31'd0, bus.instr_valid}, 32'd0);
      check("req_after_accept", {31'd0, bus.imem_req}, 32'd1);
      check("next_addr", bus.imem_addr, next_addr);
      check("fetch_count", bus.fetch_count, count);
      $display("accept  jump=%0b br=%0b next=%h count=%0d", j, br, next_addr, count);
   endtask

   initial begin
      bus.imem_ack      = 1'b0;
      bus.imem_rdata    = '0;
      bus.instr_ready   = 1'b0;
      bus.jump          = 1'b0;
      bus.jump_target   = '0;
      bus.branch_taken  = 1'b0;
      bus.branch_offset = '0;

      // Asynchronous reset mid-cycle, before any clock edge.
      #2 rst = 1'b1;
      #1;
      check("rst_req", {31'd0, bus.imem_req}, 32'd0);
      check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
      check("rst_out", bus.instr_out, 32'd0);
      check("rst_instr_pc", bus.instr_pc, RPC);
      check("rst_count", bus.fetch_count, 32'd0);
      check("rst_addr", bus.imem_addr, RPC);
      #9 rst = 1'b0;
      #1;
      check("idle_req", {31'd0, bus.imem_req}, 32'd0);
      tick();
      $display("reset   released, first request addr=%h", bus.imem_addr);

      // Sequential fetch; second word waits two cycles for its ack.
      fetch_word(RPC, 32'h2008_0005, 0);
      accept(1'b0, 26'd0, 1'b0, 16'd0, 32'h0040_0004, 32'd1);
      fetch_word(32'h0040_0004, 32'h2009_0003, 2);

      // Backpressure: stray acks and redirect inputs must be ignored.
      for (int i = 0; i < 5; i++) begin
         bus.imem_ack     = (i % 2 == 0);
         bus.imem_rdata   = 32'h0BAD_0000 + i;
         bus.jump         = 1'b1;
         bus.branch_taken = 1'b1;
         tick();
         check("bp_valid", {31'd0, bus.instr_valid}, 32'd1);
         check("bp_out", bus.instr_out, 32'h2009_0003);
         check("bp_pc", bus.instr_pc, 32'h0040_0004);
         check("bp_req", {31'd0, bus.imem_req}, 32'd0);
         $display("stall   cycle=%0d ack=%0b", i, bus.imem_ack);
      end
      bus.imem_ack     = 1'b0;
      bus.jump         = 1'b0;
      bus.branch_taken = 1'b0;
      accept(1'b0, 26'd0, 1'b0, 16'd0, 32'h0040_0008, 32'd2);

      // Jump from 0x00400008 to 0x00400040.
      fetch_word(32'h0040_0008, 32'h0810_0010, 0);
      accept(1'b1, 26'h010_0010, 1'b0, 16'd0, 32'h0040_0040, 32'd3);

      // Backward branch 0x00400044 - 0x34 = 0x00400010.
      fetch_word(32'h0040_0040, 32'h1000_FFF3, 0);
      accept(1'b0, 26'd0, 1'b1, 16'hFFF3, 32'h0040_0010, 32'd4);

      // Branch 0x00400014 - 0x10 = 0x00400004.
      fetch_word(32'h0040_0010, 32'h1000_FFFC, 0);
      accept(1'b0, 26'd0, 1'b1, 16'hFFFC, 32'h0040_0004, 32'd5);

      // Jump and branch together: jump to 0 wins.
      fetch_word(32'h0040_0004, 32'h0800_0000, 0);
      accept(1'b1, 26'd0, 1'b1, 16'h0010, 32'h0000_0000, 32'd6);

      // Branch below zero wraps to 0xFFFFFFFC, then +4 wraps back to 0.
      fetch_word(32'h0000_0000, 32'h1000_FFFE, 0);
      accept(1'b0, 26'd0, 1'b1, 16'hFFFE, 32'hFFFF_FFFC, 32'd7);
      fetch_word(32'hFFFF_FFFC, 32'h0000_0000, 0);
      accept(1'b0, 26'd0, 1'b0, 16'd0, 32'h0000_0000, 32'd8);

      // Reset pulse while in REQ; an ack right after release must be ignored.
      rst = 1'b1;
      #1;
      check("mid_rst_req", {31'd0, bus.imem_req}, 32'd0);
      check("mid_rst_addr", bus.imem_addr, RPC);
      check("mid_rst_count", bus.fetch_count, 32'd0);
      check("mid_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
      tick();
      rst            = 1'b0;
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
      tick();
      bus.imem_ack   = 1'b0;
      check("post_rst_req", {31'd0, bus.imem_req}, 32'd1);
      check("post_rst_addr", bus.imem_addr, RPC);
      check("post_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
      check("post_rst_out", bus.instr_out, 32'd0);
      check("post_rst_count", bus.fetch_count, 32'd0);
      $display("reset   mid-request, restart addr=%h", bus.imem_addr);
      fetch_word(RPC, 32'h2008_0005, 0);
      accept(1'b0, 26'd0, 1'b0, 16'd0, 32'h0040_0004, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
